conv3x3_mac_rgb888: RTL and testbench

- Downstream consumer of the 3x3 RGB888 window generator. Captures one 9-tap window per valid pulse and runs a sequential 3x3 convolution per colour channel, one tap per cycle, using a signed 8-bit kernel.
- Holds the window generator with oBusy while computing.
- Emits one saturated RGB888 result with a raster-order write address for the result BRAM, plus a frame-done pulse.

---
 rtl/conv3x3_mac_rgb888.sv | 154 +++++++++++++++
 tb/tb_conv3x3_mac_rgb888.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_mac_rgb888.sv
// conv3x3_mac_rgb888: sequential 3x3 convolution over an RGB888 window.
// One window is captured per valid pulse, one tap per cycle is accumulated
// for each colour channel, and the rounded, shifted, clamped result is
// written out with a raster-order address for the result BRAM.
module conv3x3_mac_rgb888 #(
   parameter int DATA_W = 24,
   parameter int COEF_W = 8,
   parameter int ADDR_W = 17,
   parameter int DEPTH  = 130560,
   parameter int ACC_W  = 21
) (
   input  logic                  iClk,
   input  logic                  iRst,
   input  logic                  iEn,
   input  logic                  iValid,
   input  logic [DATA_W-1:0]     iWin0,
   input  logic [DATA_W-1:0]     iWin1,
   input  logic [DATA_W-1:0]     iWin2,
   input  logic [DATA_W-1:0]     iWin3,
   input  logic [DATA_W-1:0]     iWin4,
   input  logic [DATA_W-1:0]     iWin5,
   input  logic [DATA_W-1:0]     iWin6,
   input  logic [DATA_W-1:0]     iWin7,
   input  logic [DATA_W-1:0]     iWin8,
   input  logic [9*COEF_W-1:0]   iCoef,
   input  logic [3:0]            iShift,
   output logic                  oBusy,
   output logic [DATA_W-1:0]     oPixel,
   output logic                  oValid,
   output logic [ADDR_W-1:0]     oAddr,
   output logic                  oFrameDone,
   output logic                  oOverrun
);

   localparam int PROD_W = COEF_W + 9;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, MAC, SAT, OUT} state_t;

   state_t                    state;
   logic [DATA_W-1:0]         winQ  [9];
   logic signed [COEF_W-1:0]  coefQ [9];
   logic [3:0]                shiftQ;
   logic [3:0]                tap;
   logic signed [ACC_W-1:0]   accR, accG, accB;
   logic                      validQ, frameQ;
   logic [DATA_W-1:0]         pixSel;
   logic signed [COEF_W-1:0]  coefSel;

   // Unsigned 8-bit pixel times signed coefficient, sign-extended to ACC_W.
   function automatic logic signed [ACC_W-1:0] mul(input logic [7:0] px,
                                                   input logic signed [COEF_W-1:0] c);
      logic signed [PROD_W-1:0] a, b, p;
      a = {{(PROD_W-8){1'b0}}, px};
      b = {{(PROD_W-COEF_W){c[COEF_W-1]}}, c};
      p = a * b;
      return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
   endfunction

   // Round-half-up, arithmetic shift, then clamp to 0..255.
   function automatic logic [7:0] sat8(input logic signed [ACC_W-1:0] a,
                                       input logic [3:0] sh);
      logic signed [ACC_W-1:0] rnd, r;
      rnd = (sh == 4'd0) ? '0 : (ACC_W'(1) << (sh - 4'd1));
      r   = (a + rnd) >>> sh;
      if (r < 0)
         return '0;
      else if (r > 255)
         return '1;
      else
         return r[7:0];
   endfunction

   // Select the current tap's pixel and coefficient from the captured window.
   always_comb begin
      pixSel  = winQ[tap];
      coefSel = coefQ[tap];
   end

   // Control FSM, per-channel accumulators and registered result outputs.
   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         state    <= IDLE;
         tap      <= '0;
         shiftQ   <= '0;
         accR     <= '0;
         accG     <= '0;
         accB     <= '0;
         oPixel   <= '0;
         oAddr    <= '0;
         validQ   <= 1'b0;
         frameQ   <= 1'b0;
         oOverrun <= 1'b0;
         for (int unsigned k = 0; k < 9; k++) begin
            winQ[k]  <= '0;
            coefQ[k] <= '0;
         end
      end else if (iEn) begin
         validQ <= 1'b0;
         frameQ <= 1'b0;
         if (iValid && state != IDLE)
            oOverrun <= 1'b1;
         case (state)
            IDLE: begin
               if (iValid) begin
                  winQ[0] <= iWin0;
                  winQ[1] <= iWin1;
                  winQ[2] <= iWin2;
                  winQ[3] <= iWin3;
                  winQ[4] <= iWin4;
                  winQ[5] <= iWin5;
                  winQ[6] <= iWin6;
                  winQ[7] <= iWin7;
                  winQ[8] <= iWin8;
                  for (int unsigned k = 0; k < 9; k++)
                     coefQ[k] <= iCoef[k*COEF_W +: COEF_W];
                  shiftQ <= iShift;
                  accR   <= '0;
                  accG   <= '0;
                  accB   <= '0;
                  tap    <= '0;
                  state  <= MAC;
               end
            end
            MAC: begin
               accR <= accR + mul(pixSel[23:16], coefSel);
               accG <= accG + mul(pixSel[15:8],  coefSel);
               accB <= accB + mul(pixSel[7:0],   coefSel);
               if (tap == 4'd8)
                  state <= SAT;
               else
                  tap <= tap + 4'd1;
            end
            SAT: begin
               oPixel <= {sat8(accR, shiftQ), sat8(accG, shiftQ), sat8(accB, shiftQ)};
               validQ <= 1'b1;
               frameQ <= (oAddr == LAST_ADDR);
               state  <= OUT;
            end
            OUT: begin
               oAddr <= (oAddr == LAST_ADDR) ? '0 : oAddr + ADDR_W'(1);
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Strobes are held in registers but masked while the block is frozen.
   assign oBusy      = (state != IDLE);
   assign oValid     = validQ & iEn;
   assign oFrameDone = frameQ & iEn;

endmodule

// File: tb/tb_conv3x3_mac_rgb888.sv
// Directed testbench for conv3x3_mac_rgb888 (built with a 4-pixel frame).
module tb_conv3x3_mac_rgb888;

   localparam logic [71:0] ID_COEF  = 72'h00_00_00_00_40_00_00_00_00;
   localparam logic [71:0] BOX_COEF = 72'h01_01_01_01_01_01_01_01_01;
   localparam logic [71:0] LAP_COEF = 72'hFF_FF_FF_FF_08_FF_FF_FF_FF;

   logic        iClk = 1'b0;
   logic        iRst = 1'b0;
   logic        iEn = 1'b1;
   logic        iValid = 1'b0;
   logic [23:0] winT [9];
   logic [71:0] iCoef = '0;
   logic [3:0]  iShift = '0;
   logic        oBusy, oValid, oFrameDone, oOverrun;
   logic [23:0] oPixel;
   logic [16:0] oAddr;

   int checks = 0;
   int errors = 0;

   conv3x3_mac_rgb888 #(.DEPTH(4)) dut (
      .iClk(iClk), .iRst(iRst), .iEn(iEn), .iValid(iValid),
      .iWin0(winT[0]), .iWin1(winT[1]), .iWin2(winT[2]),
      .iWin3(winT[3]), .iWin4(winT[4]), .iWin5(winT[5]),
      .iWin6(winT[6]), .iWin7(winT[7]), .iWin8(winT[8]),
      .iCoef(iCoef), .iShift(iShift),
      .oBusy(oBusy), .oPixel(oPixel), .oValid(oValid),
      .oAddr(oAddr), .oFrameDone(oFrameDone), .oOverrun(oOverrun)
   );

   always #5 iClk = ~iClk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic setWin(input logic [23:0] centre, input logic [23:0] others);
      for (int i = 0; i < 9; i++) winT[i] = others;
      winT[4] = centre;
   endtask

   task automatic doReset();
      @(negedge iClk);
      iRst = 1'b0;
      repeat (2) @(negedge iClk);
      iRst = 1'b1;
   endtask

   // One-cycle valid pulse, captured on the following rising edge.
   task automatic fire();
      @(negedge iClk);
      iValid = 1'b1;
      @(posedge iClk);
      #1 iValid = 1'b0;
   endtask

   // Count falling edges until oValid; lat = -1 when the budget expires.
   task automatic waitResult(input int start, output int lat, output int busyCnt,
                             output logic [23:0] px, output logic [16:0] addr,
                             output logic fd);
      lat = -1; busyCnt = 0; px = 'x; addr = 'x; fd = 1'bx;
      for (int n = start + 1; n <= start + 40; n++) begin
         @(negedge iClk);
         if (oBusy) busyCnt++;
         if (oValid) begin
            lat = n; px = oPixel; addr = oAddr; fd = oFrameDone;
            break;
         end
      end
   endtask

   task automatic test_reset();
      checks++;
      if ({oBusy, oValid, oFrameDone, oOverrun} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 0000", {oBusy, oValid, oFrameDone, oOverrun});
      end
      checks++;
      if (oPixel !== 24'h0) begin
         errors++; $display("FAIL reset_pixel: got %h expected 000000", oPixel);
      end
      checks++;
      if (oAddr !== 17'd0) begin
         errors++; $display("FAIL reset_addr: got %0d expected 0", oAddr);
      end
   endtask

   task automatic test_identity();
      int lat, bc; logic [23:0] px; logic [16:0] ad; logic fd;
      iCoef = ID_COEF; iShift = 4'd6;
      setWin(24'h12AB7F, 24'hFFFFFF);
      fire();
      waitResult(0, lat, bc, px, ad, fd);
      checks++;
      if (px !== 24'h12AB7F) begin errors++; $display("FAIL identity_pixel: got %h expected 12ab7f", px); end
      checks++;
      if (lat !== 11) begin errors++; $display("FAIL identity_latency: got %0d expected 11", lat); end
      checks++;
      if (bc !== 11) begin errors++; $display("FAIL identity_busy_len: got %0d expected 11", bc); end
      checks++;
      if ({ad, fd} !== {17'd0, 1'b0}) begin errors++; $display("FAIL identity_addr: got %0d/%b expected 0/0", ad, fd); end
      @(negedge iClk);
      checks++;
      if ({oBusy, oValid} !== 2'b00) begin errors++; $display("FAIL identity_after: got busy/valid %b expected 00", {oBusy, oValid}); end
   endtask

   task automatic test_box();
      int lat, bc; logic [23:0] px; logic [16:0] ad; logic fd;
      iCoef = BOX_COEF; iShift = 4'd3;
      setWin(24'h080808, 24'h080808);
      fire();
      waitResult(0, lat, bc, px, ad, fd);
      checks++;
      if ({px, ad} !== {24'h090909, 17'd1}) begin errors++; $display("FAIL box_08: got %h@%0d expected 090909@1", px, ad); end
      setWin(24'h0F0F0F, 24'h0F0F0F);
      fire();
      waitResult(0, lat, bc, px, ad, fd);
      checks++;
      if ({px, ad} !== {24'h111111, 17'd2}) begin errors++; $display("FAIL box_0f_round: got %h@%0d expected 111111@2", px, ad); end
   endtask

   task automatic test_laplacian();
      int lat, bc; logic [23:0] px; logic [16:0] ad; logic fd;
      iCoef = LAP_COEF; iShift = 4'd0;
      setWin(24'h505050, 24'h505050);
      fire();
      waitResult(0, lat, bc, px, ad, fd);
      checks++;
      if ({px, ad, fd} !== {24'h000000, 17'd3, 1'b1}) begin
         errors++; $display("FAIL lap_uniform: got %h@%0d fd=%b expected 000000@3 fd=1", px, ad, fd);
      end
      setWin(24'hFF0000, 24'h000000);
      fire();
      waitResult(0, lat, bc, px, ad, fd);
      checks++;
      if ({px, ad, fd} !== {24'hFF0000, 17'd0, 1'b0}) begin
         errors++; $display("FAIL lap_clamp_high: got %h@%0d fd=%b expected ff0000@0 fd=0", px, ad, fd);
      end
      setWin(24'h000000, 24'h00FF00);
      fire();
      waitResult(0, lat, bc, px, ad, fd);
      checks++;
      if ({px, ad} !== {24'h000000, 17'd1}) begin errors++; $display("FAIL lap_clamp_low: got %h@%0d expected 000000@1", px, ad); end
   endtask

   task automatic test_back_to_back();
      int lat, bc; logic [23:0] px; logic [16:0] ad; logic fd;
      logic [23:0] cen [5];
      logic [16:0] expAd [5];
      cen   = '{24'h010203, 24'h405060, 24'hFFFFFF, 24'h7F8081, 24'hA5C3E1};
      expAd = '{17'd0, 17'd1, 17'd2, 17'd3, 17'd0};
      doReset();
      iCoef = ID_COEF; iShift = 4'd6;
      for (int i = 0; i < 5; i++) begin
         setWin(cen[i], 24'h123456);
         fire();
         waitResult(0, lat, bc, px, ad, fd);
         checks++;
         if ({px, ad, fd} !== {cen[i], expAd[i], (i == 3)}) begin
            errors++;
            $display("FAIL b2b_%0d: got %h@%0d fd=%b expected %h@%0d fd=%b", i, px, ad, fd, cen[i], expAd[i], (i == 3));
         end
         checks++;
         if (lat !== 11) begin errors++; $display("FAIL b2b_latency_%0d: got %0d expected 11", i, lat); end
      end
      checks++;
      if (oOverrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b expected 0", oOverrun); end
   endtask

   task automatic test_overrun();
      int lat, bc; logic [23:0] px; logic [16:0] ad; logic fd;
      iCoef = ID_COEF; iShift = 4'd6;
      setWin(24'h345678, 24'h000000);
      fire();
      repeat (4) @(negedge iClk);
      setWin(24'hEEEEEE, 24'hEEEEEE);
      iCoef = BOX_COEF;
      iValid = 1'b1;
      @(posedge iClk);
      #1 iValid = 1'b0;
      waitResult(4, lat, bc, px, ad, fd);
      checks++;
      if ({px, ad} !== {24'h345678, 17'd1}) begin errors++; $display("FAIL overrun_result: got %h@%0d expected 345678@1", px, ad); end
      checks++;
      if (lat !== 11) begin errors++; $display("FAIL overrun_latency: got %0d expected 11", lat); end
      checks++;
      if (oOverrun !== 1'b1) begin errors++; $display("FAIL overrun_flag: got %b expected 1", oOverrun); end
   endtask

   task automatic test_enable_stall();
      int lat, bc; logic [23:0] px; logic [16:0] ad; logic fd;
      iCoef = ID_COEF; iShift = 4'd6;
      setWin(24'h5A3C96, 24'h777777);
      fire();
      repeat (2) @(negedge iClk);
      iEn = 1'b0;
      iCoef = '0; iShift = 4'd0;
      repeat (5) @(negedge iClk);
      checks++;
      if (oBusy !== 1'b1) begin errors++; $display("FAIL stall_busy: got %b expected 1", oBusy); end
      iEn = 1'b1;
      waitResult(7, lat, bc, px, ad, fd);
      checks++;
      if ({px, ad} !== {24'h5A3C96, 17'd2}) begin errors++; $display("FAIL stall_result: got %h@%0d expected 5a3c96@2", px, ad); end
      checks++;
      if (lat !== 16) begin errors++; $display("FAIL stall_latency: got %0d expected 16", lat); end
   endtask

   task automatic test_reset_sat();
      int lat, bc; logic [23:0] px; logic [16:0] ad; logic fd;
      iCoef = ID_COEF; iShift = 4'd6;
      setWin(24'h0C0D0E, 24'h000000);
      fire();
      repeat (10) @(negedge iClk);
      #2 iRst = 1'b0;
      #1;
      checks++;
      if ({oBusy, oValid, oFrameDone, oOverrun, oPixel, oAddr} !== 45'd0) begin
         errors++;
         $display("FAIL reset_in_sat: got busy=%b val=%b fd=%b ovr=%b pix=%h addr=%0d expected all 0",
                  oBusy, oValid, oFrameDone, oOverrun, oPixel, oAddr);
      end
      @(negedge iClk);
      iRst = 1'b1;
      setWin(24'h9ABCDE, 24'h000000);
      fire();
      waitResult(0, lat, bc, px, ad, fd);
      checks++;
      if ({px, ad} !== {24'h9ABCDE, 17'd0}) begin errors++; $display("FAIL post_reset_capture: got %h@%0d expected 9abcde@0", px, ad); end
   endtask

   initial begin
      setWin(24'h0, 24'h0);
      repeat (3) @(negedge iClk);
      test_reset();
      iRst = 1'b1;
      test_identity();
      test_box();
      test_laplacian();
      test_back_to_back();
      test_overrun();
      test_enable_stall();
      test_reset_sat();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
